// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Pipelined decode: register file with write-back bypass, load-use
//            hazard detection and a registered ID/EX stage with valid/ready.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int R0_ZERO    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rt,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_c_regDst,
    input  logic                  i_c_regWrite,
    input  logic                  i_c_memRead,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0]     i_wb_data,
    input  logic                  i_flush,
    input  logic                  i_ex_ready,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_op1,
    output logic [DATA_W-1:0]     o_op2,
    output logic [REG_ADDR_W-1:0] o_wrAddr,
    output logic                  o_regWrite,
    output logic                  o_memRead
);

    localparam int c_NUM_REGS = 1 << REG_ADDR_W;

    logic [DATA_W-1:0]     r_regs [c_NUM_REGS];
    logic                  r_valid;
    logic [DATA_W-1:0]     r_op1;
    logic [DATA_W-1:0]     r_op2;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic                  r_reg_write;
    logic                  r_mem_read;

    logic                  w_wr_en;
    logic [DATA_W-1:0]     w_op1;
    logic [DATA_W-1:0]     w_op2;
    logic [REG_ADDR_W-1:0] w_dst;
    logic                  w_hazard;
    logic                  w_advance;

    assign w_wr_en = i_wb_we && !((R0_ZERO != 0) && (i_wb_addr == '0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // Hardwired zero wins over the bypass so a write-back to r0 never leaks.
    always_comb begin
        w_op1 = r_regs[i_rs];
        if (i_wb_we && (i_wb_addr == i_rs)) w_op1 = i_wb_data;
        if ((R0_ZERO != 0) && (i_rs == '0)) w_op1 = '0;
    end

    always_comb begin
        w_op2 = r_regs[i_rt];
        if (i_wb_we && (i_wb_addr == i_rt)) w_op2 = i_wb_data;
        if ((R0_ZERO != 0) && (i_rt == '0)) w_op2 = '0;
    end

    assign w_dst = i_c_regDst ? i_rd : i_rt;

    // Rt is compared even when unused by the instruction: conservative stall.
    assign w_hazard = r_valid && r_mem_read && r_reg_write && (r_wr_addr != '0)
                   && i_valid && ((r_wr_addr == i_rs) || (r_wr_addr == i_rt));

    assign w_advance = !r_valid || i_ex_ready;
    assign o_ready   = w_advance && !w_hazard;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_wr_addr   <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (i_flush || (w_advance && (w_hazard || !i_valid))) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (w_advance) begin
            r_valid     <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_wr_addr   <= w_dst;
            r_reg_write <= i_c_regWrite;
            r_mem_read  <= i_c_memRead;
        end
    end

    assign o_valid    = r_valid;
    assign o_op1      = r_op1;
    assign o_op2      = r_op2;
    assign o_wrAddr   = r_wr_addr;
    assign o_regWrite = r_reg_write;
    assign o_memRead  = r_mem_read;

endmodule
`default_nettype wire
